// File: rtl/q2_pkg.sv
// q2_pkg: shared state encoding and default run width for the Q2 sequencer
package q2_pkg;
  localparam int Q2_WIDTH = 8;
  typedef enum logic [2:0] {S_IDLE, S_DUT_RST, S_DRIVE, S_FLUSH, S_DONE} q2_state_e;
endpackage

// File: rtl/q2_resp_capture.sv
// q2_resp_capture: MSB-first shift capture of one response bit
module q2_resp_capture #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;
  always_ff @(posedge clk)
    q_q <= (rst_i || clr_i) ? '0 : en_i ? {q_q[WIDTH-2:0], d_i} : q_q;
  assign q_o = q_q;
endmodule

// File: rtl/q2_seq_ctrl.sv
// q2_seq_ctrl: drives a stimulus word into sequential_circuit_Q2 and captures its b/c responses
module q2_seq_ctrl
  import q2_pkg::*;
#(
  parameter int WIDTH = Q2_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic             b_in,
  input  logic             c_in,
  output logic             a_out,
  output logic             dut_rstn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] b_cap,
  output logic [WIDTH-1:0] c_cap
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  q2_state_e        state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sr_q;
  logic             a_q, dut_rstn_q, busy_q, done_q;
  logic             cap_clr, cap_en;
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      a_q        <= 1'b0;
      dut_rstn_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (abort && state_q != S_IDLE) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= 1'b0;
      dut_rstn_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          dut_rstn_q <= !start;
          busy_q     <= start;
          if (start) begin
            sr_q    <= pattern;
            state_q <= S_DUT_RST;
          end
        end
        S_DUT_RST: begin
          state_q    <= S_DRIVE;
          dut_rstn_q <= 1'b1;
          cnt_q      <= '0;
          a_q        <= sr_q[WIDTH-1];
          sr_q       <= {sr_q[WIDTH-2:0], 1'b0};
        end
        S_DRIVE: begin
          if (cnt_q == LAST) begin
            state_q <= S_FLUSH;
            cnt_q   <= '0;
            a_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            a_q   <= sr_q[WIDTH-1];
            sr_q  <= {sr_q[WIDTH-2:0], 1'b0};
          end
        end
        S_FLUSH: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  // the response to drive bit k arrives one cycle later, so sampling skips cnt=0 and ends on FLUSH
  assign cap_clr = !rstn && state_q == S_IDLE && start;
  assign cap_en  = !rstn && !abort && ((state_q == S_DRIVE && cnt_q != '0) || state_q == S_FLUSH);
  q2_resp_capture #(.WIDTH(WIDTH)) u_cap_b (
    .clk(clk), .rst_i(rstn), .clr_i(cap_clr), .en_i(cap_en), .d_i(b_in), .q_o(b_cap)
  );
  q2_resp_capture #(.WIDTH(WIDTH)) u_cap_c (
    .clk(clk), .rst_i(rstn), .clr_i(cap_clr), .en_i(cap_en), .d_i(c_in), .q_o(c_cap)
  );
  assign a_out    = a_q;
  assign dut_rstn = dut_rstn_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_q2_seq_ctrl.sv
// tb_q2_seq_ctrl: directed vectors with a done-triggered scoreboard for q2_seq_ctrl
module tb_q2_seq_ctrl;
  logic       clk = 1'b0;
  logic       rstn = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0] pattern = '0;
  logic       b_in, c_in, a_out, dut_rstn, busy, done;
  logic [7:0] b_cap, c_cap;
  logic       loop = 1'b0, b_const = 1'b0, c_const = 1'b0, a_dly = 1'b0;
  typedef struct packed {logic [7:0] b; logic [7:0] c;} exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0, done_cnt = 0;
  logic [7:0] a5 = 8'hA5;

  q2_seq_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .pattern(pattern),
    .b_in(b_in), .c_in(c_in), .a_out(a_out), .dut_rstn(dut_rstn), .busy(busy),
    .done(done), .b_cap(b_cap), .c_cap(c_cap)
  );

  always #5 clk = ~clk;
  // stand-in for sequential_circuit_Q2: b echoes a one cycle late, c is its inverse
  always @(posedge clk) a_dly <= a_out;
  assign b_in = loop ? a_dly : b_const;
  assign c_in = loop ? ~a_dly : c_const;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (done) begin
    exp_t e;
    done_cnt++;
    if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      chk("b_cap", {24'd0, b_cap}, {24'd0, e.b});
      chk("c_cap", {24'd0, c_cap}, {24'd0, e.c});
    end
  end

  task automatic pulse_start(input logic [7:0] p);
    pattern = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_a_out"}, {31'd0, a_out}, 32'd0);
    chk({tag, "_dut_rstn"}, {31'd0, dut_rstn}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_b_cap"}, {24'd0, b_cap}, 32'd0);
    chk({tag, "_c_cap"}, {24'd0, c_cap}, 32'd0);
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    chk_reset_outs("rst");
    rstn = 1'b0;
    @(negedge clk);
    chk("post_rst_dut_rstn", {31'd0, dut_rstn}, 32'd1);

    // timing and loopback, pattern A5
    loop = 1'b1;
    sb.push_back('{b: 8'hA5, c: 8'h5A});
    pulse_start(8'hA5);
    chk("c1_dut_rstn", {31'd0, dut_rstn}, 32'd0);
    chk("c1_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("drive_a_out", {31'd0, a_out}, {31'd0, a5[7-k]});
      chk("drive_dut_rstn", {31'd0, dut_rstn}, 32'd1);
      chk("drive_done", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    chk("flush_a_out", {31'd0, a_out}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("c11_done", {31'd0, done}, 32'd1);
    chk("c11_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("c12_done", {31'd0, done}, 32'd0);
    chk("c12_busy", {31'd0, busy}, 32'd0);
    chk("hold_b_cap", {24'd0, b_cap}, 32'hA5);

    // constant responses
    loop = 1'b0; b_const = 1'b1; c_const = 1'b0;
    sb.push_back('{b: 8'hFF, c: 8'h00});
    pulse_start(8'h3C);
    wait_done();
    loop = 1'b1;
    sb.push_back('{b: 8'h3C, c: 8'hC3});
    pulse_start(8'h3C);
    wait_done();

    // abort in cycle 5, then a normal run
    pulse_start(8'hFF);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_a_out", {31'd0, a_out}, 32'd0);
    chk("abort_dut_rstn", {31'd0, dut_rstn}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (8) @(negedge clk);
    sb.push_back('{b: 8'h96, c: 8'h69});
    pulse_start(8'h96);
    wait_done();

    // start with abort in IDLE is accepted
    abort = 1'b1;
    sb.push_back('{b: 8'h01, c: 8'hFE});
    pulse_start(8'h01);
    abort = 1'b0;
    wait_done();

    // starts while busy in cycles 3 and 10 are ignored
    loop = 1'b0; b_const = 1'b0; c_const = 1'b1;
    d0 = done_cnt;
    sb.push_back('{b: 8'h00, c: 8'hFF});
    pulse_start(8'h55);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    chk("busy_start_done_count", done_cnt - d0, 32'd1);
    chk("busy_start_idle", {31'd0, busy}, 32'd0);

    // reset in cycle 6, then a full run
    b_const = 1'b1;
    pulse_start(8'hF0);
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk_reset_outs("midrst");
    rstn = 1'b0;
    @(negedge clk);
    sb.push_back('{b: 8'hFF, c: 8'hFF});
    pulse_start(8'hF0);
    wait_done();

    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/q2_seq_ctrl.md
Q2_SEQ_CTRL -- requirements
Module: q2_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, number of stimulus bits per run (2..32).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rstn  in  1  reset, synchronous and active-high (1 = reset), sampled on rising clk.
REQ-004 start  in  1  run request, sampled only in IDLE.
REQ-005 abort  in  1  cancel an in-progress run.
REQ-006 pattern  in  WIDTH  stimulus word, captured on accepted start.
REQ-007 b_in  in  1  sequential_circuit_Q2 output b.
REQ-008 c_in  in  1  sequential_circuit_Q2 output c.
REQ-009 a_out  out  1  registered drive to sequential_circuit_Q2 input a.
REQ-010 dut_rstn  out  1  registered active-low reset to sequential_circuit_Q2.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse on run completion.
REQ-013 b_cap  out  WIDTH  captured b response word.
REQ-014 c_cap  out  WIDTH  captured c response word.

Function
REQ-015 FSM states SHALL be: IDLE, DUT_RST, DRIVE, FLUSH, DONE.
REQ-016 IDLE with start=1 SHALL latch pattern into a shift register and move to DUT_RST; otherwise it stays in IDLE.
REQ-017 DUT_RST SHALL last exactly 1 cycle with dut_rstn=0, then move to DRIVE; dut_rstn=1 in all other states.
REQ-018 DRIVE SHALL last exactly WIDTH cycles with bit counter cnt=0..WIDTH-1; a_out = pattern[WIDTH-1-cnt], MSB first.
REQ-019 After the DRIVE cycle with cnt=WIDTH-1, the FSM SHALL go to FLUSH for 1 cycle, then DONE for 1 cycle, then IDLE.
REQ-020 a_out SHALL be 0 outside DRIVE.
REQ-021 b_cap and c_cap SHALL shift left and insert b_in and c_in at the LSB on every edge ending a DRIVE cycle with cnt>=1, and on the edge ending FLUSH.
REQ-022 Exactly WIDTH samples are taken per run; the first sample ends in the MSB.
REQ-023 b_cap and c_cap SHALL be cleared on the accepted start edge and held stable outside a run.
REQ-024 done SHALL be 1 only in the DONE state.
REQ-025 Minimum start-to-start period is WIDTH+4 cycles; start while busy SHALL be ignored (no queueing).
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done pulse and dut_rstn=1; captures keep their partial contents.
REQ-027 Simultaneous start and abort in IDLE: abort has no effect and start is accepted.
REQ-028 The counter SHALL be $clog2(WIDTH) bits and SHALL NOT wrap inside DRIVE.

Reset
REQ-029 With rstn=1 at a rising edge: state=IDLE, cnt=0, a_out=0, dut_rstn=0, busy=0, done=0, b_cap=0, c_cap=0.
REQ-030 The first edge with rstn=0 SHALL set dut_rstn=1; reset mid-run SHALL abandon the run as in REQ-029.
REQ-031 Reset SHALL take priority over start and abort.

Structure
REQ-032 FSM state encoding and the default WIDTH SHALL live in shared package q2_pkg.
REQ-033 The capture shift logic SHALL be one sub-module, q2_resp_capture, instantiated once per response bit (b, c).
REQ-034 There SHALL be no combinational path from any input to any output.

Verification (WIDTH=8, start pulsed at edge E0)
REQ-035 Timing: pattern=8'hA5 -> dut_rstn=0 in cycle 1; a_out = 1,0,1,0,0,1,0,1 in cycles 2..9; done=1 in cycle 11 only; busy=1 in cycles 1..11.
REQ-036 Loopback: b_in driven by a one-cycle-registered copy of a_out, pattern=8'hA5 -> b_cap=8'hA5 at done.
REQ-037 Constant inputs: b_in=1, c_in=0 -> b_cap=8'hFF, c_cap=8'h00 at done.
REQ-038 Abort: abort=1 in cycle 5 -> IDLE in cycle 6, no done pulse, a_out=0; a new start is then accepted normally.
REQ-039 Busy start: second start pulses in cycles 3 and 10 -> ignored, exactly one done pulse.
REQ-040 Mid-run reset: rstn=1 in cycle 6 -> all outputs at reset values on the next edge; a start after rstn deasserts runs a full sequence.
